hdmi_timing_gen: RTL
====================

Name: hdmi_timing_gen

Overview:
- Free-running raster timing generator for one CEA-861-D video format.
- Consumes the format record returned by the shared `hdmi_attr` package's `video_attr_for_id` lookup.
- Produces pixel coordinates, data-enable, a one-cycle-early pixel request, sync pulses with correct polarity, and frame/line markers.
- Sits between the pixel source (pattern generator or framebuffer reader) and the TMDS/packet assembly stage.

Parameters:
- VIDEO_ID_CODE, 1, CEA-861-D format code; must be one supported by `video_attr_for_id` (elaboration error otherwise).
- BIT_WIDTH, $clog2(frame_width), width of cx; elaboration error if too narrow for frame_width-1.
- BIT_HEIGHT, $clog2(frame_height), width of cy; elaboration error if too narrow for frame_height-1.

Ports:
- clk_pixel  input  1  pixel clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  advance raster by one pixel when high; hold all state when low.
- cx  output  BIT_WIDTH  current column, 0..frame_width-1.
- cy  output  BIT_HEIGHT  current line, 0..frame_height-1.
- de  output  1  current position is active video.
- pixel_req  output  1  position reached on the next enabled edge is active (prefetch strobe).
- hsync  output  1  horizontal sync, polarity per invert.
- vsync  output  1  vertical sync, polarity per invert.
- frame_start  output  1  high while at (0,0).
- line_start  output  1  high while cx==0.

Behaviour:
- Attributes: a = video_attr_for_id(VIDEO_ID_CODE), evaluated at elaboration; all comparisons use a.* as constants.
- State: cx and cy only; all other outputs are registered functions of them, aligned to the same cycle as cx/cy.
- Reset (async, immediate):
  - cx=frame_width-1, cy=frame_height-1 (last pixel of frame).
  - de=0, frame_start=0, line_start=0, pixel_req=1.
  - hsync=vsync=invert (deasserted level).
- Advance on each clk_pixel edge with enable=1:
  - cx wraps frame_width-1 -> 0.
  - On that wrap, cy increments; cy wraps frame_height-1 -> 0.
  - First enabled edge after reset lands on (0,0): de=1, frame_start=1, line_start=1.
- enable=0: cx, cy and every output hold their values; markers stay high if already high (level, not pulse).
- Active region: de=1 iff cx<screen_width && cy<screen_height.
- pixel_req: equals de evaluated at the successor position (wrap rules applied). Exactly one cycle ahead of de under continuous enable; during enable-low stretches it holds.
- hsync: asserted iff screen_width+hsync_pulse_start <= cx < screen_width+hsync_pulse_start+hsync_pulse_size. Applies on every line, including vertical blanking.
- vsync start/end point: HS0 = screen_width+hsync_pulse_start.
  - Asserts at (HS0, screen_height+vsync_pulse_start).
  - Deasserts at (HS0, screen_height+vsync_pulse_start+vsync_pulse_size).
  - Asserted interval includes the start point and excludes the end point.
  - The deassert line may exceed frame_height-1; it wraps modulo frame_height, and the asserted interval then spans the frame boundary.
- Polarity: output = asserted XOR invert. Negative-going when invert=1; idle level equals invert.
- Arithmetic: all bounds are elaboration-time integers. Counter compares are unsigned at BIT_WIDTH/BIT_HEIGHT. No runtime adders beyond the +1 increments.
- Mid-frame reset: immediately returns to the reset state; no partial sync pulse persists after reset asserts.
- Latency: 0 cycles from cx/cy to de/sync/markers (same-cycle aligned); pixel_req leads de by exactly 1 enabled cycle.

Decomposition:
- Add to package hdmi_attr:
  - function `hsync_start(video_attr_t)` returning screen_width+hsync_pulse_start.
  - function `vsync_line_start(video_attr_t)` returning screen_height+vsync_pulse_start.
  - function `bits_for(int)` for width checks.
- One natural sub-module: hdmi_raster_counter, a cx/cy wrap counter with enable and reset-to-last-pixel. The sync/de decode stays in hdmi_timing_gen.

Test Plan:
- VIC 1, enable=1 continuously, reset released:
  - 1st edge -> cx=0, cy=0, de=1, frame_start=1.
  - cx=639,cy=0 -> de=1; cx=640 -> de=0.
  - frame_start recurs every 800*525=420000 cycles.
- VIC 1 hsync: low for cx 656..751 on every line (96 cycles), high elsewhere; check lines 0, 479, 524.
- VIC 1 vsync:
  - Goes low at (656,490), returns high at (656,492), i.e. 1600 cycles low.
  - Low on line 491 at cx=0; high at (655,490).
- VIC 4 polarity: hsync high for cx 1390..1429; vsync high from (1390,725) to (1390,730); both idle low; de=1 for cx<1280 && cy<720.
- enable toggled pseudo-randomly, VIC 1:
  - cx/cy/outputs frozen while enable=0.
  - pixel_req at each enabled edge equals de on the following enabled cycle.
  - Sequence of (cx,cy) visited identical to the continuous run.
- Reset asserted at (700,491) mid-vsync, VIC 1:
  - Same cycle (async): hsync=vsync=1, de=0, pixel_req=1.
  - After release, first enabled edge at (0,0).

Source files
------------

// File: rtl/hdmi_attr.sv
// hdmi_attr: CEA-861-D video format records and helpers.
//   video_attr_for_id(id)  -> timing record for a format code (valid=0 if unsupported)
//   hsync_start(a)         -> first column of the horizontal sync pulse
//   vsync_line_start(a)    -> line on which the vertical sync pulse begins
//   bits_for(n)            -> bits needed to hold the unsigned value n
//   frame_width_for / frame_height_for -> frame size by id, for parameter defaults
package hdmi_attr;

    typedef struct packed {
        logic valid;
        logic invert;
        int   screen_width;
        int   screen_height;
        int   frame_width;
        int   frame_height;
        int   hsync_pulse_start;
        int   hsync_pulse_size;
        int   vsync_pulse_start;
        int   vsync_pulse_size;
    } video_attr_t;

    function automatic video_attr_t make_attr(
        input int sw, input int sh, input int fw, input int fh,
        input int hps, input int hpz, input int vps, input int vpz,
        input logic inv
    );
        video_attr_t a;
        a.valid             = 1'b1;
        a.invert            = inv;
        a.screen_width      = sw;
        a.screen_height     = sh;
        a.frame_width       = fw;
        a.frame_height      = fh;
        a.hsync_pulse_start = hps;
        a.hsync_pulse_size  = hpz;
        a.vsync_pulse_start = vps;
        a.vsync_pulse_size  = vpz;
        return a;
    endfunction

    function automatic video_attr_t video_attr_for_id(input int id);
        video_attr_t a;
        case (id)
            32'sd1:         a = make_attr(32'sd640,  32'sd480,  32'sd800,  32'sd525,  32'sd16,  32'sd96, 32'sd10, 32'sd2, 1'b1);
            32'sd2, 32'sd3: a = make_attr(32'sd720,  32'sd480,  32'sd858,  32'sd525,  32'sd16,  32'sd62, 32'sd9,  32'sd6, 1'b1);
            32'sd4:         a = make_attr(32'sd1280, 32'sd720,  32'sd1650, 32'sd750,  32'sd110, 32'sd40, 32'sd5,  32'sd5, 1'b0);
            32'sd16:        a = make_attr(32'sd1920, 32'sd1080, 32'sd2200, 32'sd1125, 32'sd88,  32'sd44, 32'sd4,  32'sd5, 1'b0);
            default: begin
                // Small dummy frame keeps derived widths legal until the elaboration check fires.
                a       = make_attr(32'sd1, 32'sd1, 32'sd2, 32'sd2, 32'sd0, 32'sd1, 32'sd0, 32'sd1, 1'b0);
                a.valid = 1'b0;
            end
        endcase
        return a;
    endfunction

    function automatic int hsync_start(input video_attr_t a);
        return a.screen_width + a.hsync_pulse_start;
    endfunction

    function automatic int vsync_line_start(input video_attr_t a);
        return a.screen_height + a.vsync_pulse_start;
    endfunction

    function automatic int bits_for(input int value);
        int bits;
        bits = 32'sd1;
        for (int b = 1; b < 31; b++) begin
            if (value >= (32'sd1 << b)) begin
                bits = b + 32'sd1;
            end
        end
        return bits;
    endfunction

    function automatic int frame_width_for(input int id);
        video_attr_t a;
        a = video_attr_for_id(id);
        return a.frame_width;
    endfunction

    function automatic int frame_height_for(input int id);
        video_attr_t a;
        a = video_attr_for_id(id);
        return a.frame_height;
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_raster_counter.sv
// hdmi_timing_gen_raster_counter: cx/cy raster position counter.
//   clk_i, reset_i (async, active-high), enable_i (advance one pixel)
//   cx_o/cy_o           current position; resets to the last pixel of the frame
//   cx_next_o/cy_next_o position reached on the next enabled edge
module hdmi_timing_gen_raster_counter #(
    parameter int W       = 10,
    parameter int H       = 10,
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 525
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         enable_i,
    output logic [W-1:0] cx_o,
    output logic [H-1:0] cy_o,
    output logic [W-1:0] cx_next_o,
    output logic [H-1:0] cy_next_o
);

    localparam logic [W-1:0] X_LAST = W'(FRAME_W - 1);
    localparam logic [H-1:0] Y_LAST = H'(FRAME_H - 1);
    localparam logic [W-1:0] X_ONE  = W'(1);
    localparam logic [H-1:0] Y_ONE  = H'(1);

    logic [W-1:0] cx_q, cx_d;
    logic [H-1:0] cy_q, cy_d;

    // Successor position with column and line wrap, then enable-gated next state.
    always_comb begin
        cx_next_o = cx_q + X_ONE;
        cy_next_o = cy_q;
        if (cx_q == X_LAST) begin
            cx_next_o = '0;
            cy_next_o = (cy_q == Y_LAST) ? '0 : cy_q + Y_ONE;
        end else begin
            cy_next_o = cy_q;
        end
        if (enable_i) begin
            cx_d = cx_next_o;
            cy_d = cy_next_o;
        end else begin
            cx_d = cx_q;
            cy_d = cy_q;
        end
    end

    // Position register; reset parks on the last pixel so the first step lands on (0,0).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cx_q <= X_LAST;
            cy_q <= Y_LAST;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o = cx_q;
    assign cy_o = cy_q;

endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: free-running raster timing for one CEA-861-D format.
//   clk_pixel, reset (async, active-high), enable (advance one pixel)
//   cx/cy        current column/line
//   de           active video at (cx,cy)
//   pixel_req    active video at the position reached on the next enabled edge
//   hsync/vsync  sync pulses, idle level equals the format's invert bit
//   frame_start  high at (0,0); line_start high at cx==0
module hdmi_timing_gen
    import hdmi_attr::*;
#(
    parameter int VIDEO_ID_CODE = 1,
    parameter int BIT_WIDTH     = $clog2(frame_width_for(VIDEO_ID_CODE)),
    parameter int BIT_HEIGHT    = $clog2(frame_height_for(VIDEO_ID_CODE))
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  enable,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  de,
    output logic                  pixel_req,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output logic                  line_start
);

    localparam video_attr_t A = video_attr_for_id(VIDEO_ID_CODE);

    localparam int   FW       = A.frame_width;
    localparam int   FH       = A.frame_height;
    localparam int   HS0      = hsync_start(A);
    localparam int   HS1      = HS0 + A.hsync_pulse_size;
    localparam int   VS0      = vsync_line_start(A);
    localparam int   VE_RAW   = VS0 + A.vsync_pulse_size;
    // When the pulse runs past the last line, the end point wraps into the next frame.
    localparam logic VS_WRAPS = (VE_RAW >= FH);
    localparam int   VE       = VS_WRAPS ? (VE_RAW - FH) : VE_RAW;

    localparam logic [BIT_WIDTH-1:0]  X_LAST_C = BIT_WIDTH'(FW - 1);
    localparam logic [BIT_WIDTH-1:0]  X_ONE_C  = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0]  SW_C     = BIT_WIDTH'(A.screen_width);
    localparam logic [BIT_WIDTH-1:0]  HS0_C    = BIT_WIDTH'(HS0);
    localparam logic [BIT_WIDTH-1:0]  HS1_C    = BIT_WIDTH'(HS1);
    localparam logic [BIT_HEIGHT-1:0] Y_LAST_C = BIT_HEIGHT'(FH - 1);
    localparam logic [BIT_HEIGHT-1:0] Y_ONE_C  = BIT_HEIGHT'(1);
    localparam logic [BIT_HEIGHT-1:0] SH_C     = BIT_HEIGHT'(A.screen_height);
    localparam logic [BIT_HEIGHT-1:0] VS0_C    = BIT_HEIGHT'(VS0);
    localparam logic [BIT_HEIGHT-1:0] VE_C     = BIT_HEIGHT'(VE);

    if (!A.valid) begin : g_bad_vic
        $error("hdmi_timing_gen: unsupported VIDEO_ID_CODE %0d", VIDEO_ID_CODE);
    end
    if (bits_for(FW - 1) > BIT_WIDTH) begin : g_bad_width
        $error("hdmi_timing_gen: BIT_WIDTH %0d too narrow for frame width %0d", BIT_WIDTH, FW);
    end
    if (bits_for(FH - 1) > BIT_HEIGHT) begin : g_bad_height
        $error("hdmi_timing_gen: BIT_HEIGHT %0d too narrow for frame height %0d", BIT_HEIGHT, FH);
    end

    function automatic logic active_at(input logic [BIT_WIDTH-1:0] x, input logic [BIT_HEIGHT-1:0] y);
        return (x < SW_C) && (y < SH_C);
    endfunction

    function automatic logic hsync_at(input logic [BIT_WIDTH-1:0] x);
        return (x >= HS0_C) && (x < HS1_C);
    endfunction

    // True when (x,y) is at or beyond column xs of line ys in raster order.
    function automatic logic reached(input logic [BIT_WIDTH-1:0] x, input logic [BIT_HEIGHT-1:0] y,
                                     input logic [BIT_WIDTH-1:0] xs, input logic [BIT_HEIGHT-1:0] ys);
        return (y > ys) || ((y == ys) && (x >= xs));
    endfunction

    function automatic logic vsync_at(input logic [BIT_WIDTH-1:0] x, input logic [BIT_HEIGHT-1:0] y);
        logic past_start;
        logic past_end;
        past_start = reached(x, y, HS0_C, VS0_C);
        past_end   = reached(x, y, HS0_C, VE_C);
        return VS_WRAPS ? (past_start || !past_end) : (past_start && !past_end);
    endfunction

    logic [BIT_WIDTH-1:0]  cx_next_s, cx_ahead_s;
    logic [BIT_HEIGHT-1:0] cy_next_s, cy_ahead_s;
    logic de_q, de_d, pixel_req_q, pixel_req_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic frame_start_q, frame_start_d, line_start_q, line_start_d;

    hdmi_timing_gen_raster_counter #(
        .W       (BIT_WIDTH),
        .H       (BIT_HEIGHT),
        .FRAME_W (FW),
        .FRAME_H (FH)
    ) u_counter (
        .clk_i     (clk_pixel),
        .reset_i   (reset),
        .enable_i  (enable),
        .cx_o      (cx),
        .cy_o      (cy),
        .cx_next_o (cx_next_s),
        .cy_next_o (cy_next_s)
    );

    // Decode outputs for the position the counter moves to, so they align with cx/cy.
    always_comb begin
        cx_ahead_s = cx_next_s + X_ONE_C;
        cy_ahead_s = cy_next_s;
        if (cx_next_s == X_LAST_C) begin
            cx_ahead_s = '0;
            cy_ahead_s = (cy_next_s == Y_LAST_C) ? '0 : cy_next_s + Y_ONE_C;
        end else begin
            cy_ahead_s = cy_next_s;
        end
        de_d          = de_q;
        pixel_req_d   = pixel_req_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        line_start_d  = line_start_q;
        if (enable) begin
            de_d          = active_at(cx_next_s, cy_next_s);
            pixel_req_d   = active_at(cx_ahead_s, cy_ahead_s);
            hsync_d       = hsync_at(cx_next_s) ^ A.invert;
            vsync_d       = vsync_at(cx_next_s, cy_next_s) ^ A.invert;
            frame_start_d = (cx_next_s == '0) && (cy_next_s == '0);
            line_start_d  = (cx_next_s == '0);
        end else begin
            de_d = de_q;
        end
    end

    // Output registers; reset values match the decode of the last pixel of the frame.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            de_q          <= 1'b0;
            pixel_req_q   <= 1'b1;
            hsync_q       <= A.invert;
            vsync_q       <= A.invert;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            de_q          <= de_d;
            pixel_req_q   <= pixel_req_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign de          = de_q;
    assign pixel_req   = pixel_req_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule
